// File: rtl/shared_stage_scheduler_pkg.sv
// shared_stage_scheduler_pkg: scheduler state type and index-width helper
package shared_stage_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    function automatic int idx_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_stage_scheduler_if.sv
// shared_stage_scheduler_if: requester/response handshake bundle of the shared-stage scheduler
interface shared_stage_scheduler_if
    import shared_stage_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = idx_width(NUM_REQ)
);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [NUM_REQ-1:0] rsp_ready;
    logic [SEL_W-1:0]   op_sel;
    logic               unit_start;
    logic               capture_en;
    logic               flush;
    logic               busy;

    modport master (
        input  req_valid, rsp_ready, flush,
        output req_ready, op_sel, unit_start, capture_en, rsp_valid, busy
    );

    modport slave (
        output req_valid, rsp_ready, flush,
        input  req_ready, op_sel, unit_start, capture_en, rsp_valid, busy
    );
endinterface

// File: rtl/shared_stage_scheduler_rr_arbiter.sv
// shared_stage_scheduler_rr_arbiter: round-robin pick of the first valid requester at or after ptr
module shared_stage_scheduler_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   idx,
    output logic               any_valid
);
    logic [NUM_REQ-1:0] rot;
    int                 off;

    // rotate so bit 0 is the pointer position, then take the lowest set offset
    always_comb begin
        rot = NUM_REQ'({req, req} >> ptr);
        off = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (rot[SEL_W'(k)]) off = k;
        idx       = SEL_W'((int'(ptr) + off) % NUM_REQ);
        any_valid = |req;
        gnt       = '0;
        if (any_valid) gnt[idx] = 1'b1;
    end
endmodule

// File: rtl/shared_stage_scheduler.sv
// shared_stage_scheduler: round-robin sharing of one fixed-latency, non-pipelined unit
module shared_stage_scheduler
    import shared_stage_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 7
) (
    input logic                     clk,
    input logic                     rst,
    shared_stage_scheduler_if.master bus
);
    localparam int SEL_W = idx_width(NUM_REQ);
    localparam int CNT_W = idx_width(LATENCY + 1);

    sched_state_e       state, state_n;
    logic [SEL_W-1:0]   owner, rr_ptr, win;
    logic [CNT_W-1:0]   count;
    logic [NUM_REQ-1:0] win_oh;
    logic               any_req, in_resp, rsp_hs, grant, done;

    shared_stage_scheduler_rr_arbiter #(.NUM_REQ(NUM_REQ), .SEL_W(SEL_W)) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .gnt       (win_oh),
        .idx       (win),
        .any_valid (any_req)
    );

    // next state and outputs; flush masks every strobe and forces IDLE
    always_comb begin
        in_resp        = state == RESP && !bus.flush;
        rsp_hs         = in_resp && bus.rsp_ready[owner];
        grant          = !bus.flush && any_req && (state == IDLE || rsp_hs);
        done           = state == RUN && !bus.flush && count == CNT_W'(LATENCY);
        state_n        = bus.flush ? IDLE : grant ? RUN : done ? RESP : rsp_hs ? IDLE : state;
        bus.req_ready  = grant ? win_oh : '0;
        bus.unit_start = grant;
        bus.op_sel     = grant ? win : owner;
        bus.capture_en = done;
        bus.busy       = state != IDLE;
        bus.rsp_valid  = '0;
        if (in_resp) bus.rsp_valid[owner] = 1'b1;
    end

    // state, owner, round-robin pointer and latency counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            count  <= '0;
        end else begin
            state <= state_n;
            if (grant) begin
                owner  <= win;
                rr_ptr <= (win == SEL_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                count  <= CNT_W'(1);
            end else if (done || bus.flush) begin
                count <= '0;
            end else if (state == RUN) begin
                count <= count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_shared_stage_scheduler.sv
// tb_shared_stage_scheduler: directed and random checks of two scheduler instances against a timeline model
module tb_shared_stage_scheduler;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   checks = 0;
    int   failures = 0;

    shared_stage_scheduler_if #(.NUM_REQ(4)) ifa ();
    shared_stage_scheduler_if #(.NUM_REQ(4)) ifb ();

    shared_stage_scheduler #(.NUM_REQ(4), .LATENCY(7)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    shared_stage_scheduler #(.NUM_REQ(4), .LATENCY(1)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%h expected=%h t=%0t", nm, d, act, exp, $time);
        end
    endtask

    // Model: each op is a timeline; grant at t0, capture at t0+L, response from t0+L+1
    int m_act[2], m_t0[2], m_own[2], m_ptr[2], m_ok[2];
    int lat[2] = '{7, 1};
    int mcyc = 0;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [3:0] rv, rr, a_rdy, a_rsp, e_rdy, e_rsp;
            logic [1:0] a_op;
            logic       fl, rs, a_us, a_ce, a_busy;
            int         el, win;
            bit         in_resp, cap, hs, can;
            rv     = d == 0 ? ifa.req_valid  : ifb.req_valid;
            rr     = d == 0 ? ifa.rsp_ready  : ifb.rsp_ready;
            fl     = d == 0 ? ifa.flush      : ifb.flush;
            rs     = d == 0 ? rst_a          : rst_b;
            a_rdy  = d == 0 ? ifa.req_ready  : ifb.req_ready;
            a_rsp  = d == 0 ? ifa.rsp_valid  : ifb.rsp_valid;
            a_op   = d == 0 ? ifa.op_sel     : ifb.op_sel;
            a_us   = d == 0 ? ifa.unit_start : ifb.unit_start;
            a_ce   = d == 0 ? ifa.capture_en : ifb.capture_en;
            a_busy = d == 0 ? ifa.busy       : ifb.busy;
            el      = mcyc - m_t0[d];
            in_resp = m_act[d] != 0 && el > lat[d];
            cap     = m_act[d] != 0 && el == lat[d] && !fl;
            hs      = in_resp && !fl && rr[2'(m_own[d])];
            can     = !fl && (m_act[d] == 0 || hs) && rv != 4'b0;
            win     = 0;
            for (int k = 3; k >= 0; k--)
                if (rv[2'((m_ptr[d] + k) % 4)]) win = (m_ptr[d] + k) % 4;
            e_rdy = can ? (4'b0001 << win) : 4'b0000;
            e_rsp = (in_resp && !fl) ? (4'b0001 << m_own[d]) : 4'b0000;
            if (m_ok[d] != 0) begin
                chk("req_ready", d, 32'(a_rdy), 32'(e_rdy));
                chk("unit_start", d, 32'(a_us), 32'(can));
                chk("op_sel", d, 32'(a_op), can ? 32'(win) : 32'(m_own[d]));
                chk("capture_en", d, 32'(a_ce), 32'(cap));
                chk("rsp_valid", d, 32'(a_rsp), 32'(e_rsp));
                chk("busy", d, 32'(a_busy), 32'(m_act[d] != 0));
            end
            if (rs) begin
                m_act[d] = 0; m_ptr[d] = 0; m_own[d] = 0; m_ok[d] = 1;
            end else if (fl) begin
                m_act[d] = 0;
            end else if (can) begin
                m_act[d] = 1; m_t0[d] = mcyc; m_own[d] = win; m_ptr[d] = (win + 1) % 4;
            end else if (hs) begin
                m_act[d] = 0;
            end
        end
        mcyc++;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic reset_a();
        ifa.req_valid = '0; ifa.rsp_ready = '0; ifa.flush = 1'b0;
        rst_a = 1'b1;
        step(2);
        rst_a = 1'b0;
    endtask

    function automatic logic [3:0] nxt_req(input logic [3:0] cur, input logic [3:0] g);
        logic [3:0] n;
        n = (cur & ~g) | (4'($urandom) & 4'($urandom));
        if ($urandom_range(0, 19) == 0) n = n & 4'($urandom);
        return n;
    endfunction

    logic [3:0] ga, gb;

    initial begin
        ifb.req_valid = '0; ifb.rsp_ready = '0; ifb.flush = 1'b0;
        rst_b = 1'b1;
        reset_a();
        rst_b = 1'b0;
        settle();
        chk("reset_busy", 0, 32'(ifa.busy), 32'h0);
        chk("reset_rsp", 0, 32'(ifa.rsp_valid), 32'h0);

        // single request, latency 7
        step(); ifa.req_valid = 4'b0001; ifa.rsp_ready = 4'b1111; settle();
        chk("t1_ready", 0, 32'(ifa.req_ready), 32'h1);
        chk("t1_start", 0, 32'(ifa.unit_start), 32'h1);
        step(); ifa.req_valid = 4'b0000;
        step(6); settle();
        chk("t1_capture", 0, 32'(ifa.capture_en), 32'h1);
        step(); settle();
        chk("t1_rsp", 0, 32'(ifa.rsp_valid), 32'h1);
        step(); settle();
        chk("t1_idle", 0, 32'(ifa.busy), 32'h0);

        // all requesting: grants rotate every LATENCY+1 cycles
        reset_a();
        step(); ifa.req_valid = 4'b1111; ifa.rsp_ready = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) step();
            settle();
            chk("t2_onehot", 0, 32'($countones(ifa.req_ready) <= 1), 32'h1);
            if (c % 8 == 0) chk("t2_grant", 0, 32'(ifa.req_ready), 32'h1 << ((c / 8) % 4));
        end

        // response back-pressure delays the next grant
        reset_a();
        step(); ifa.req_valid = 4'b0001; ifa.rsp_ready = 4'b0000;
        step(); ifa.req_valid = 4'b1110;
        step(7); settle();
        chk("t3_rsp8", 0, 32'(ifa.rsp_valid), 32'h1);
        step(4); settle();
        chk("t3_noready12", 0, 32'(ifa.req_ready), 32'h0);
        chk("t3_rsp12", 0, 32'(ifa.rsp_valid), 32'h1);
        step(); ifa.rsp_ready = 4'b1111; settle();
        chk("t3_rsp13", 0, 32'(ifa.rsp_valid), 32'h1);
        chk("t3_grant13", 0, 32'(ifa.req_ready), 32'h2);
        step(); ifa.req_valid = 4'b0000;
        step(10);

        // flush mid-run drops the op but keeps the pointer advance
        reset_a();
        step(); ifa.req_valid = 4'b0100; ifa.rsp_ready = 4'b1111; settle();
        chk("t4_grant", 0, 32'(ifa.req_ready), 32'h4);
        step(); ifa.req_valid = 4'b0000;
        step(2); ifa.flush = 1'b1; settle();
        chk("t4_flush_ce", 0, 32'(ifa.capture_en), 32'h0);
        step(); ifa.flush = 1'b0; settle();
        chk("t4_idle", 0, 32'(ifa.busy), 32'h0);
        step(); ifa.req_valid = 4'b1111; settle();
        chk("t4_next", 0, 32'(ifa.req_ready), 32'h8);
        step(); ifa.req_valid = 4'b0000; settle();
        chk("t4_no_old_capture", 0, 32'(ifa.capture_en), 32'h0);
        step(12);

        // reset during RESP
        reset_a();
        step(); ifa.req_valid = 4'b1111; ifa.rsp_ready = 4'b0000;
        step(); ifa.req_valid = 4'b0000;
        step(8); rst_a = 1'b1;
        step(); rst_a = 1'b0; settle();
        chk("t5_rsp", 0, 32'(ifa.rsp_valid), 32'h0);
        chk("t5_busy", 0, 32'(ifa.busy), 32'h0);
        chk("t5_ready", 0, 32'(ifa.req_ready), 32'h0);
        step(); ifa.req_valid = 4'b1111; settle();
        chk("t5_grant0", 0, 32'(ifa.req_ready), 32'h1);
        step(); ifa.req_valid = 4'b0000; ifa.rsp_ready = 4'b1111;
        step(10);

        // LATENCY=1 instance
        step(); ifb.req_valid = 4'b0100; ifb.rsp_ready = 4'b1111; settle();
        chk("t6_grant", 1, 32'(ifb.req_ready), 32'h4);
        step(); ifb.req_valid = 4'b0000; settle();
        chk("t6_capture", 1, 32'(ifb.capture_en), 32'h1);
        step(); settle();
        chk("t6_rsp", 1, 32'(ifb.rsp_valid), 32'h4);
        step(); settle();
        chk("t6_idle", 1, 32'(ifb.busy), 32'h0);

        // random traffic on both instances
        ga = '0; gb = '0;
        for (int c = 0; c < 3000; c++) begin
            step();
            ifa.req_valid = nxt_req(ifa.req_valid, ga);
            ifb.req_valid = nxt_req(ifb.req_valid, gb);
            ifa.rsp_ready = 4'($urandom);
            ifb.rsp_ready = 4'($urandom);
            ifa.flush     = $urandom_range(0, 39) == 0;
            ifb.flush     = $urandom_range(0, 39) == 0;
            rst_a         = $urandom_range(0, 249) == 0;
            rst_b         = $urandom_range(0, 249) == 0;
            settle();
            ga = ifa.req_valid & ifa.req_ready;
            gb = ifb.req_valid & ifb.req_ready;
        end

        step();
        ifa.req_valid = '0; ifb.req_valid = '0; ifa.flush = 1'b0; ifb.flush = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0; ifa.rsp_ready = 4'b1111; ifb.rsp_ready = 4'b1111;
        step(20);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
